// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer. in_ready comes straight from a flop.
// Also provides flush, NOP bubble insertion on empty, and saturating stall/bubble counters.
module if_id_skid_reg #(
    parameter int          XLEN     = 64,
    parameter int          ILEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_inst,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_inst,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // State bits are {main_valid, skid_valid}; S_ILLEGAL cannot be reached.
    typedef enum logic [1:0] {
        S_EMPTY   = 2'b00,
        S_ILLEGAL = 2'b01,
        S_ONE     = 2'b10,
        S_FULL    = 2'b11
    } state_t;

    localparam logic [ILEN-1:0] NOP_W = ILEN'(NOP_INST);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_main_pc;
    logic [ILEN-1:0]  r_main_inst;
    logic [XLEN-1:0]  r_skid_pc;
    logic [ILEN-1:0]  r_skid_inst;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_drain;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;
    logic w_stall;
    logic w_bubble;

    assign w_main_valid = r_state[1];
    assign w_skid_valid = r_state[0];
    assign w_accept     = in_valid & ~w_skid_valid;
    assign w_drain      = w_main_valid & out_ready;
    assign w_stall      = w_main_valid & ~out_ready;
    assign w_bubble     = ~w_main_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_ld_main_in = 1'b1;
                    w_state_nxt  = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_ld_main_in = 1'b1;
                end else if (w_accept) begin
                    w_ld_skid   = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_drain) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // A redirect discards everything, including whatever fetch offers this cycle.
        if (flush) begin
            w_state_nxt    = S_EMPTY;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_main_pc   <= '0;
            r_main_inst <= NOP_W;
            r_skid_pc   <= '0;
            r_skid_inst <= NOP_W;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_main_pc   <= '0;
                r_main_inst <= NOP_W;
            end else if (w_ld_main_in) begin
                r_main_pc   <= in_pc;
                r_main_inst <= in_inst;
            end else if (w_ld_main_skid) begin
                r_main_pc   <= r_skid_pc;
                r_main_inst <= r_skid_inst;
            end
            if (w_ld_skid) begin
                r_skid_pc   <= in_pc;
                r_skid_inst <= in_inst;
            end
        end
    end

    // Counters look at the pre-edge handshake, so flush cycles still count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = ~w_skid_valid;
    assign out_valid  = w_main_valid;
    assign out_pc     = r_main_pc;
    assign out_inst   = w_main_valid ? r_main_inst : NOP_W;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed vector tables, hand-written corner sequences,
// and a FIFO scoreboard/reference model checked every cycle.
module tb_if_id_skid_reg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int CNT_W = 4;
    localparam int CMAX = 15;
    localparam logic [31:0] NOP = 32'h00000013;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [ILEN-1:0]  in_inst;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [ILEN-1:0]  out_inst;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    if_id_skid_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } ent_t;

    typedef struct {
        logic            iv;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            ordy;
        logic            ev;
        logic            eir;
        logic [XLEN-1:0] epc;
        logic [ILEN-1:0] einst;
        int              est;
        int              ebub;
    } vec_t;

    int              checks = 0;
    int              errors = 0;
    ent_t            q[$];
    int              m_stall;
    int              m_bub;
    logic [XLEN-1:0] m_last_pc;
    vec_t            tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after a posedge, then move to the sampling point mid-cycle.
    task automatic apply(input logic iv, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #4;
    endtask

    // Compare against the model, advance the model, then clock.
    task automatic tick();
        logic acc;
        logic drn;
        ent_t e;
        chk("illegal_state", 64'(dut.r_state == 2'b01), 64'd0);
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_pc_head", out_pc, q[0].pc);
            chk("out_inst_head", 64'(out_inst), 64'(q[0].inst));
        end else begin
            chk("out_inst_nop", 64'(out_inst), 64'(NOP));
            chk("out_pc_idle", out_pc, m_last_pc);
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (q.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
        if (q.size() == 0 && out_ready && m_bub < CMAX) m_bub++;
        if (flush) begin
            q.delete();
            m_last_pc = '0;
        end else begin
            if (drn) begin
                e = q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_inst", 64'(out_inst), 64'(e.inst));
            end
            if (acc) q.push_back('{pc: in_pc, inst: in_inst});
            if (q.size() > 0) m_last_pc = q[0].pc;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge with whatever inputs are present, then one idle cycle.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        q.delete();
        m_stall   = 0;
        m_bub     = 0;
        m_last_pc = '0;
        #4;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'(NOP));
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stream at full rate, then back-pressure into the skid entry.
        tbl[0]  = '{1'b1, 64'h1000, 32'hAAAA0001, 1'b1, 1'b0, 1'b1, 64'h0,    NOP,          0, 0};
        tbl[1]  = '{1'b1, 64'h1004, 32'hAAAA0002, 1'b1, 1'b1, 1'b1, 64'h1000, 32'hAAAA0001, 0, 1};
        tbl[2]  = '{1'b1, 64'h1008, 32'hAAAA0003, 1'b1, 1'b1, 1'b1, 64'h1004, 32'hAAAA0002, 0, 1};
        tbl[3]  = '{1'b0, 64'h0,    32'h0,        1'b1, 1'b1, 1'b1, 64'h1008, 32'hAAAA0003, 0, 1};
        tbl[4]  = '{1'b0, 64'h0,    32'h0,        1'b1, 1'b0, 1'b1, 64'h1008, NOP,          0, 1};
        tbl[5]  = '{1'b1, 64'h2000, 32'hCCCC0001, 1'b1, 1'b0, 1'b1, 64'h0,    NOP,          0, 0};
        tbl[6]  = '{1'b1, 64'h2004, 32'hCCCC0002, 1'b0, 1'b1, 1'b1, 64'h2000, 32'hCCCC0001, 0, 1};
        tbl[7]  = '{1'b1, 64'h2008, 32'hCCCC0003, 1'b0, 1'b1, 1'b0, 64'h2000, 32'hCCCC0001, 1, 1};
        tbl[8]  = '{1'b1, 64'h2008, 32'hCCCC0003, 1'b0, 1'b1, 1'b0, 64'h2000, 32'hCCCC0001, 2, 1};
        tbl[9]  = '{1'b1, 64'h2008, 32'hCCCC0003, 1'b1, 1'b1, 1'b0, 64'h2000, 32'hCCCC0001, 3, 1};
        tbl[10] = '{1'b1, 64'h2008, 32'hCCCC0003, 1'b1, 1'b1, 1'b1, 64'h2004, 32'hCCCC0002, 3, 1};
        tbl[11] = '{1'b0, 64'h0,    32'h0,        1'b1, 1'b1, 1'b1, 64'h2008, 32'hCCCC0003, 3, 1};
        tbl[12] = '{1'b0, 64'h0,    32'h0,        1'b1, 1'b0, 1'b1, 64'h2008, NOP,          3, 1};

        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        m_stall = 0; m_bub = 0; m_last_pc = '0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            if (i == 5) do_reset();
            apply(tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].eir));
            chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_inst", i), 64'(out_inst), 64'(tbl[i].einst));
            chk($sformatf("tbl%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].est));
            chk($sformatf("tbl%0d_bubble", i), 64'(bubble_cnt), 64'(tbl[i].ebub));
            tick();
        end

        // Flush while FULL, with a new fetch offered in the same cycle.
        do_reset();
        apply(1'b1, 64'h3000, 32'hBBBB0001, 1'b0, 1'b0); tick();
        apply(1'b1, 64'h3004, 32'hBBBB0002, 1'b0, 1'b0); tick();
        apply(1'b1, 64'h3008, 32'hBBBB0003, 1'b0, 1'b1);
        chk("pre_flush_full", 64'(in_ready), 64'd0);
        tick();
        apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_inst", 64'(out_inst), 64'(NOP));
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_pc", out_pc, 64'd0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            tick();
        end

        // Idle decode: ten bubble cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("idle_bubble10", 64'(bubble_cnt), 64'd10);

        // Long stall saturates the 4-bit counter.
        do_reset();
        apply(1'b1, 64'h5000, 32'hDDDD0001, 1'b0, 1'b0); tick();
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        apply(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_saturated", 64'(stall_cnt), 64'd15);

        // Reset while FULL, then resume streaming.
        do_reset();
        apply(1'b1, 64'h6000, 32'hEEEE0001, 1'b0, 1'b0); tick();
        apply(1'b1, 64'h6004, 32'hEEEE0002, 1'b0, 1'b0); tick();
        apply(1'b1, 64'h6008, 32'hEEEE0003, 1'b0, 1'b0);
        chk("pre_reset_full", 64'(in_ready), 64'd0);
        do_reset();
        apply(1'b1, 64'h7000, 32'hFFFF0001, 1'b1, 1'b0);
        chk("resume_latency0", 64'(out_valid), 64'd0);
        tick();
        apply(1'b1, 64'h7004, 32'hFFFF0002, 1'b1, 1'b0);
        chk("resume_latency1", out_pc, 64'h7000);
        tick();
        apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0); tick();
        apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0); tick();

        // Random traffic against the model, with occasional flushes.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 4) != 0, 64'h8000 + 64'(i * 4), 32'h1000_0000 + 32'(i),
                  ($urandom % 3) != 0, ($urandom % 30) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
